pwr_seq_ctrl: RTL and testbench

- Parametrised N-channel regulator sequencer that replaces direct register-to-enable wiring of the LV/12V regulators.
- Register requests are applied as staggered turn-on (ascending index) and turn-off (descending index), with programmable spacing.
- Active-low open-drain regulator alerts are synchronised, debounced and latched; a latched fault forces outputs off until cleared.
- Sits between the R/W register map and the VP12_EN / EN_xVx pins; status goes back to the RO register map.

---
 rtl/pwr_seq_ctrl.sv | 93 +++++++++
 tb/tb_pwr_seq_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: staggered regulator enable sequencer with debounced alert fault latching
module pwr_seq_ctrl #(
  parameter int N_CH        = 6,
  parameter int DELAY_W     = 16,
  parameter int DEBOUNCE    = 8,
  parameter bit GLOBAL_TRIP = 1'b0
) (
  input  logic               clk_axi,
  input  logic               rst,
  input  logic [N_CH-1:0]    ch_req,
  input  logic [DELAY_W-1:0] seq_delay,
  input  logic [N_CH-1:0]    alert_n,
  input  logic               fault_clr,
  output logic [N_CH-1:0]    en_out,
  output logic [N_CH-1:0]    fault_latched,
  output logic [N_CH-1:0]    first_fault,
  output logic               busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t             r_state;
  logic [N_CH-1:0]    r_sync1, r_sync2, r_req;
  logic [7:0]         r_deb [N_CH];
  logic [DELAY_W-1:0] r_cnt;
  logic [N_CH-1:0]    w_alert, w_new, w_clr, w_target, w_off, w_on, w_step, w_seq, w_en_nxt;
  logic               w_trip, w_load;
  assign w_alert  = ~r_sync2;
  assign w_trip   = GLOBAL_TRIP && (|fault_latched);
  assign w_target = w_trip ? '0 : (r_req & ~fault_latched);
  assign w_clr    = {N_CH{fault_clr}} & ~w_alert;
  assign busy     = (en_out != w_target) | (r_cnt != '0);
  // Channels whose debounce count reaches DEBOUNCE on this edge
  always_comb begin
    w_new = '0;
    for (int i = 0; i < N_CH; i++)
      w_new[i] = w_alert[i] & en_out[i] & (r_deb[i] >= 8'(DEBOUNCE - 1));
  end
  // One sequencing step: highest-index turn-off first, else lowest-index turn-on
  always_comb begin
    w_off = '0;
    w_on  = '0;
    for (int i = 0; i < N_CH; i++)
      if (en_out[i] && !w_target[i]) begin
        w_off    = '0;
        w_off[i] = 1'b1;
      end
    for (int i = N_CH - 1; i >= 0; i--)
      if (!en_out[i] && w_target[i]) begin
        w_on    = '0;
        w_on[i] = 1'b1;
      end
    w_step   = (|w_off) ? w_off : w_on;
    w_seq    = (r_state == IDLE) ? (en_out ^ w_step) : en_out;
    w_en_nxt = (GLOBAL_TRIP && (|w_new)) ? '0 : (w_seq & ~w_new);
    w_load   = (r_state == IDLE) && (|w_step) && (seq_delay != '0) && (w_seq != w_target);
  end
  // Alert synchroniser, debounce counters and sticky fault flags
  always_ff @(posedge clk_axi) begin
    if (rst) begin
      r_sync1       <= '1;
      r_sync2       <= '1;
      fault_latched <= '0;
      first_fault   <= '0;
      for (int i = 0; i < N_CH; i++) r_deb[i] <= 8'd0;
    end else begin
      r_sync1       <= alert_n;
      r_sync2       <= r_sync1;
      fault_latched <= (fault_latched & ~w_clr) | w_new;
      first_fault   <= (fault_latched == '0) ? w_new : (first_fault & ~w_clr);
      for (int i = 0; i < N_CH; i++)
        r_deb[i] <= !(w_alert[i] && en_out[i]) ? 8'd0 :
                    (r_deb[i] >= 8'(DEBOUNCE)) ? r_deb[i] : r_deb[i] + 8'd1;
    end
  end
  // Sequencer FSM; spacing is only inserted between steps of an unfinished ramp
  always_ff @(posedge clk_axi) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      en_out  <= '0;
    end else begin
      r_req  <= ch_req;
      en_out <= w_en_nxt;
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - DELAY_W'(1);
        if (r_cnt == DELAY_W'(1)) r_state <= IDLE;
      end else if (w_load) begin
        r_cnt   <= seq_delay;
        r_state <= WAIT;
      end
    end
  end
endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb_pwr_seq_ctrl: directed checks of sequencing, debounce, fault latch and reset
module tb_pwr_seq_ctrl;
  logic        clk_axi = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  ch_req = '0;
  logic [15:0] seq_delay = 16'd3;
  logic [5:0]  alert0 = '1, alert1 = '1;
  logic        fault_clr = 1'b0;
  logic [5:0]  en0, fl0, ff0, en1, fl1, ff1;
  logic        busy0, busy1;
  int          n_chk = 0, n_pass = 0, n, e;
  logic [5:0]  exp_en;

  always #5 clk_axi = ~clk_axi;

  pwr_seq_ctrl #(.N_CH(6), .DELAY_W(16), .DEBOUNCE(8), .GLOBAL_TRIP(1'b0)) u0 (
    .clk_axi(clk_axi), .rst(rst), .ch_req(ch_req), .seq_delay(seq_delay),
    .alert_n(alert0), .fault_clr(fault_clr), .en_out(en0),
    .fault_latched(fl0), .first_fault(ff0), .busy(busy0));

  pwr_seq_ctrl #(.N_CH(6), .DELAY_W(16), .DEBOUNCE(8), .GLOBAL_TRIP(1'b1)) u1 (
    .clk_axi(clk_axi), .rst(rst), .ch_req(ch_req), .seq_delay(seq_delay),
    .alert_n(alert1), .fault_clr(fault_clr), .en_out(en1),
    .fault_latched(fl1), .first_fault(ff1), .busy(busy1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk_axi);
      #1;
    end
  endtask

  task automatic pulse_clr;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_en", en0, 0);
    check("rst_fl", fl0, 0);
    check("rst_ff", ff0, 0);
    check("rst_busy", busy0, 0);
    rst = 1'b0;
    tick(3);
    // ramp-up, seq_delay=3: r=0 is the edge that samples the request
    ch_req = 6'h3F;
    for (int r = 0; r <= 23; r++) begin
      tick();
      n = (r < 1) ? 0 : ((r - 1) / 4 + 1);
      if (n > 6) n = 6;
      exp_en = 6'((1 << n) - 1);
      check($sformatf("up_en r%0d", r), en0, exp_en);
      check($sformatf("up_busy r%0d", r), busy0, 32'(r < 21));
    end
    check("up_en_u1", en1, 6'h3F);
    // ramp-down, seq_delay=0: one bit per edge, bit 5 first
    seq_delay = 16'd0;
    ch_req = 6'h00;
    for (int r = 0; r <= 7; r++) begin
      tick();
      exp_en = (r > 6) ? 6'h00 : 6'(6'h3F >> r);
      check($sformatf("dn_en r%0d", r), en0, exp_en);
      check($sformatf("dn_busy r%0d", r), busy0, 32'(r < 6));
    end
    // mid-ramp reversal during WAIT
    seq_delay = 16'd3;
    ch_req = 6'h3F;
    for (int r = 0; r <= 10; r++) tick();
    check("rev_pre", en0, 6'h07);
    ch_req = 6'h00;
    for (int r = 11; r <= 23; r++) begin
      tick();
      exp_en = (r < 13) ? 6'h07 : (r < 17) ? 6'h03 : (r < 21) ? 6'h01 : 6'h00;
      check($sformatf("rev_en r%0d", r), en0, exp_en);
    end
    // bring everything on quickly for the fault tests
    seq_delay = 16'd0;
    ch_req = 6'h3F;
    tick(8);
    check("on_u0", en0, 6'h3F);
    check("on_u1", en1, 6'h3F);
    // 7-cycle alert on channel 3: below debounce threshold
    alert0[3] = 1'b0;
    tick(7);
    alert0[3] = 1'b1;
    tick(10);
    check("short_fl", fl0, 0);
    check("short_en", en0, 6'h3F);
    // held alert on channel 3: latches at edge 2+DEBOUNCE
    alert0[3] = 1'b0;
    tick(9);
    check("deb_fl_s9", fl0, 0);
    check("deb_en_s9", en0, 6'h3F);
    tick();
    check("deb_fl_s10", fl0, 6'h08);
    check("deb_en_s10", en0, 6'h37);
    check("deb_ff_s10", ff0, 6'h08);
    check("deb_u1_en", en1, 6'h3F);
    pulse_clr();
    check("clr_held_fl", fl0, 6'h08);
    alert0[3] = 1'b1;
    tick(3);
    pulse_clr();
    check("clr_fl", fl0, 0);
    check("clr_ff", ff0, 0);
    check("clr_en_hold", en0, 6'h37);
    tick();
    check("clr_reen", en0, 6'h3F);
    // global trip on u1 channel 1
    seq_delay = 16'd3;
    alert1[1] = 1'b0;
    tick(9);
    check("gt_en_s9", en1, 6'h3F);
    tick();
    check("gt_en_s10", en1, 6'h00);
    check("gt_fl_s10", fl1, 6'h02);
    check("gt_ff_s10", ff1, 6'h02);
    check("gt_busy", busy1, 0);
    check("gt_u0_en", en0, 6'h3F);
    pulse_clr();
    check("gt_clr_held", fl1, 6'h02);
    check("gt_clr_held_ff", ff1, 6'h02);
    alert1[1] = 1'b1;
    tick(3);
    pulse_clr();
    check("gt_clr_fl", fl1, 0);
    check("gt_clr_en", en1, 0);
    tick();
    check("gt_re_b0", en1, 6'h01);
    tick(3);
    check("gt_re_b0_hold", en1, 6'h01);
    tick();
    check("gt_re_b1", en1, 6'h03);
    // reset during ramp-up with 3 channels on
    seq_delay = 16'd0;
    ch_req = 6'h00;
    tick(10);
    check("pre_rst_off", en0, 0);
    seq_delay = 16'd3;
    ch_req = 6'h3F;
    tick(11);
    check("rst_mid_pre", en0, 6'h07);
    rst = 1'b1;
    tick();
    check("rst_mid_en", en0, 0);
    check("rst_mid_busy", busy0, 0);
    check("rst_mid_fl", fl0, 0);
    check("rst_mid_ff", ff0, 0);
    rst = 1'b0;
    tick();
    check("rst_re_r12", en0, 0);
    tick();
    check("rst_re_r13", en0, 6'h01);
    tick(3);
    check("rst_re_r16", en0, 6'h01);
    tick();
    check("rst_re_r17", en0, 6'h03);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
